cs_bist: RTL and testbench

- Self-test source/sink for the CS sliding-window filter: the producer for CS input X, the consumer for CS output Y.
- Sequences the CS reset, drives a pseudo-random 8-bit sample stream, and skips the CS warm-up window.
- Compresses N_PAT valid Y words into a 16-bit MISR signature and flags pass/fail against a golden signature.
- Sits beside CS in the synthesized top for on-chip self-test; replaces file-driven stimulus during silicon bring-up.

---
 rtl/cs_bist.sv | 124 ++++++++++++
 tb/tb_cs_bist.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cs_bist.sv
`timescale 1ns/1ps
// Self-test source/sink for the CS sliding-window filter: sequences the CS reset,
// feeds an LFSR sample stream, skips the warm-up window and compresses Y into a MISR.
module cs_bist #(
    parameter int          N_PAT      = 2000,
    parameter int          LAT        = 9,
    parameter int          RST_CYC    = 2,
    parameter logic [7:0]  SEED       = 8'h01,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        cs_reset,
    output logic [7:0]  X,
    input  logic [9:0]  Y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] sample_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        FEED = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] RST_LAST  = 16'(RST_CYC - 1);
    localparam logic [15:0] CAP_FIRST = 16'(LAT);
    localparam logic [15:0] CAP_LAST  = 16'(LAT + N_PAT - 1);

    state_t      state, state_next;
    logic [7:0]  x_next;
    logic        cs_reset_next;
    logic        pass_next;
    logic [15:0] sig_next;
    logic [15:0] cnt_next;
    logic [15:0] rst_cnt, rst_cnt_next;
    logic        capture;

    // Galois LFSR, polynomial x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    // CCITT MISR step folding in one 10-bit CS output word
    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [9:0] y);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {6'b0, y};
    endfunction

    assign capture = (sample_cnt >= CAP_FIRST) && (sample_cnt <= CAP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            X          <= 8'h00;
            cs_reset   <= 1'b0;
            pass       <= 1'b0;
            signature  <= 16'hFFFF;
            sample_cnt <= 16'h0000;
            rst_cnt    <= 16'h0000;
        end else begin
            state      <= state_next;
            X          <= x_next;
            cs_reset   <= cs_reset_next;
            pass       <= pass_next;
            signature  <= sig_next;
            sample_cnt <= cnt_next;
            rst_cnt    <= rst_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        x_next        = X;
        cs_reset_next = cs_reset;
        pass_next     = pass;
        sig_next      = signature;
        cnt_next      = sample_cnt;
        rst_cnt_next  = rst_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next    = RST;
                    cs_reset_next = 1'b1;
                    pass_next     = 1'b0;
                    sig_next      = 16'hFFFF;
                    cnt_next      = 16'h0000;
                    rst_cnt_next  = 16'h0000;
                end
            end
            RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_next    = FEED;
                    cs_reset_next = 1'b0;
                    x_next        = SEED;
                    cnt_next      = 16'h0000;
                end else begin
                    rst_cnt_next = rst_cnt + 16'h0001;
                end
            end
            FEED: begin
                x_next   = lfsr_next(X);
                cnt_next = sample_cnt + 16'h0001;
                if (capture) begin
                    sig_next = misr_next(signature, Y);
                end
                // Final capture edge: judge the signature that includes this word
                if (sample_cnt == CAP_LAST) begin
                    state_next = DONE;
                    pass_next  = (sig_next == GOLDEN_SIG);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RST) || (state == FEED);
    assign done = (state == DONE);

endmodule

// File: tb/tb_cs_bist.sv
`timescale 1ns/1ps
// Scoreboard bench for cs_bist: a run-phase reference model predicts every cycle's
// outputs and each run's final signature; a monitor compares them against the DUT.
module tb_cs_bist;

    localparam int          N_PAT   = 3;
    localparam int          LAT     = 9;
    localparam int          RST_CYC = 2;
    localparam logic [7:0]  SEED    = 8'h01;
    localparam logic [15:0] GOLDEN  = 16'h8F1F;
    localparam int          T_DONE  = RST_CYC + LAT + N_PAT;

    logic        clk;
    logic        reset;
    logic        start;
    logic        cs_reset;
    logic [7:0]  X;
    logic [9:0]  Y;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [15:0] sample_cnt;

    int errors = 0;
    int checks = 0;

    cs_bist #(
        .N_PAT(N_PAT), .LAT(LAT), .RST_CYC(RST_CYC), .SEED(SEED), .GOLDEN_SIG(GOLDEN)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cs_reset(cs_reset), .X(X), .Y(Y),
        .busy(busy), .done(done), .pass(pass), .signature(signature), .sample_cnt(sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        cs_reset;
        logic        busy;
        logic        done;
        logic        pass;
        logic        chk_x;
        logic [7:0]  x;
        logic [15:0] sig;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
    } res_t;

    exp_t exp_q[$];
    res_t res_q[$];

    // Reference model: m_t counts edges since the accepted start (-1 = idle after reset)
    int          m_t = -1;
    logic [7:0]  m_x = 8'h00;
    logic [15:0] m_sig = 16'hFFFF;
    logic [15:0] m_cnt = 16'h0000;
    logic        m_pass = 1'b0;
    logic [7:0]  seq [0:254];
    logic [9:0]  pat [0:31];
    logic        prev_done = 1'b0;

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [9:0] y);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {6'b0, y};
    endfunction

    task automatic applyStimulus(input logic r, input logic s, input logic [9:0] y);
        exp_t e;
        int   k;
        @(negedge clk);
        reset = r;
        start = s;
        Y     = y;
        if (r) begin
            m_t = -1; m_x = 8'h00; m_sig = 16'hFFFF; m_cnt = 16'h0000; m_pass = 1'b0;
        end else if ((m_t < 0 || m_t == T_DONE) && s) begin
            m_t = 0; m_sig = 16'hFFFF; m_cnt = 16'h0000; m_pass = 1'b0;
        end else if (m_t >= 0 && m_t < T_DONE) begin
            k = m_t - RST_CYC;
            if (k >= LAT && k <= LAT + N_PAT - 1) m_sig = misr(m_sig, y);
            m_t = m_t + 1;
            if (m_t >= RST_CYC) begin
                k = m_t - RST_CYC;
                m_x = seq[k % 255];
                m_cnt = 16'(k);
            end
            if (m_t == T_DONE) begin
                m_pass = (m_sig == GOLDEN);
                res_q.push_back('{sig: m_sig, pass: m_pass});
            end
        end
        e.cs_reset = (m_t >= 0) && (m_t < RST_CYC);
        e.busy     = (m_t >= 0) && (m_t < T_DONE);
        e.done     = (m_t == T_DONE);
        e.pass     = m_pass;
        e.chk_x    = !e.cs_reset;
        e.x        = m_x;
        e.sig      = m_sig;
        e.cnt      = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (cs_reset !== e.cs_reset || busy !== e.busy || done !== e.done || pass !== e.pass ||
            signature !== e.sig || sample_cnt !== e.cnt || (e.chk_x && X !== e.x)) begin
            errors++;
            $display("[TB] FAIL cycle_outputs t=%0t: got cs_reset=%b busy=%b done=%b pass=%b X=%h sig=%h cnt=%0d, want cs_reset=%b busy=%b done=%b pass=%b X=%h%s sig=%h cnt=%0d",
                     $time, cs_reset, busy, done, pass, X, signature, sample_cnt,
                     e.cs_reset, e.busy, e.done, e.pass, e.x, e.chk_x ? "" : "(any)", e.sig, e.cnt);
        end
    endtask

    // Monitor: per-cycle comparison plus a run-result check whenever done rises
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
            if (done === 1'b1 && prev_done === 1'b0) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL run_result: got done=1 sig=%h, want no completed run", signature);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    if (signature !== r.sig || pass !== r.pass) begin
                        errors++;
                        $display("[TB] FAIL run_result: got sig=%h pass=%b, want sig=%h pass=%b",
                                 signature, pass, r.sig, r.pass);
                    end
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, want completion before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] v;
        reset = 1'b1;
        start = 1'b0;
        Y     = 10'h000;
        v = SEED;
        for (int i = 0; i < 255; i++) begin
            seq[i] = v;
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
        end
        for (int i = 0; i < 32; i++) pat[i] = 10'($urandom);

        repeat (2) applyStimulus(1'b1, 1'b0, 10'h000);
        repeat (2) applyStimulus(1'b0, 1'b0, 10'($urandom));

        $display("[TB] run with Y forced to 0 (golden match)");
        applyStimulus(1'b0, 1'b1, 10'h000);
        repeat (T_DONE + 2) applyStimulus(1'b0, 1'b0, 10'h000);

        $display("[TB] restart from DONE, Y bit 0 flipped on the second capture");
        applyStimulus(1'b0, 1'b1, 10'h000);
        for (int j = 1; j <= T_DONE + 1; j++)
            applyStimulus(1'b0, 1'b0, (j == RST_CYC + LAT + 2) ? 10'h001 : 10'h000);

        $display("[TB] run with Y forced to 1");
        applyStimulus(1'b0, 1'b1, 10'h001);
        repeat (T_DONE + 1) applyStimulus(1'b0, 1'b0, 10'h001);

        $display("[TB] random Y runs with stray start pulses while busy");
        for (int run = 0; run < 8; run++) begin
            applyStimulus(1'b0, 1'b1, 10'($urandom));
            for (int j = 1; j <= T_DONE + 1; j++)
                applyStimulus(1'b0, (j < T_DONE) && ($urandom_range(3) == 0), 10'($urandom));
            repeat ($urandom_range(3)) applyStimulus(1'b0, 1'b0, 10'($urandom));
        end

        $display("[TB] identical pattern twice, second started from DONE");
        for (int rep = 0; rep < 2; rep++) begin
            applyStimulus(1'b0, 1'b1, pat[0]);
            for (int j = 1; j <= T_DONE; j++) applyStimulus(1'b0, 1'b0, pat[j]);
        end
        applyStimulus(1'b0, 1'b0, 10'($urandom));

        $display("[TB] reset in the middle of FEED, no resume without start");
        applyStimulus(1'b0, 1'b1, 10'($urandom));
        repeat (RST_CYC + 5) applyStimulus(1'b0, 1'b0, 10'($urandom));
        applyStimulus(1'b1, 1'b0, 10'($urandom));
        repeat (T_DONE + 2) applyStimulus(1'b0, 1'b0, 10'($urandom));

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL queues_drained: got exp_q=%0d res_q=%0d, want 0 and 0",
                     exp_q.size(), res_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
